sparc_exu_div_yreg_ctl: RTL and testbench

Control sequencer for the per-thread Y register file in the EXU divide/multiply datapath. Tracks WRY, multiply and MULScc operations through the pipeline. Generates the one-hot, mutually exclusive write/shift/hold selects and the thread read select consumed by the Y register storage. Arbitrates same-thread write collisions and reports per-thread in-flight status to the ECL, which uses it to hold dependent RDY/MULScc issue.

---
 rtl/sparc_exu_div_yreg_ctl_if.sv | 37 +++
 rtl/sparc_exu_div_yreg_ctl.sv | 95 +++++++++
 tb/tb_sparc_exu_div_yreg_ctl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_exu_div_yreg_ctl_if.sv
// Y register control bundle between the ECL/pipeline (master) and the
// Y register write sequencer (slave).
interface sparc_exu_div_yreg_ctl_if;
  logic [1:0] tid_e;
  logic       wry_vld_w;
  logic [1:0] wry_tid_w;
  logic       flush_w;
  logic       mul_vld_g;
  logic [1:0] mul_tid_g;
  logic       mulscc_vld_e;
  logic [1:0] mulscc_tid_e;
  logic       mulscc_rs1_0_e;
  logic       kill_m;

  logic [3:0] yreg_thr_e;
  logic [3:0] yreg_wen_w;
  logic [3:0] yreg_wen_g;
  logic [3:0] yreg_shift_g;
  logic [3:0] yreg_wen_l;
  logic       yreg_data_31_g;
  logic [3:0] yreg_busy;
  logic       yreg_collide;

  modport master (
    output tid_e, wry_vld_w, wry_tid_w, flush_w, mul_vld_g, mul_tid_g,
           mulscc_vld_e, mulscc_tid_e, mulscc_rs1_0_e, kill_m,
    input  yreg_thr_e, yreg_wen_w, yreg_wen_g, yreg_shift_g, yreg_wen_l,
           yreg_data_31_g, yreg_busy, yreg_collide
  );

  modport slave (
    input  tid_e, wry_vld_w, wry_tid_w, flush_w, mul_vld_g, mul_tid_g,
           mulscc_vld_e, mulscc_tid_e, mulscc_rs1_0_e, kill_m,
    output yreg_thr_e, yreg_wen_w, yreg_wen_g, yreg_shift_g, yreg_wen_l,
           yreg_data_31_g, yreg_busy, yreg_collide
  );
endinterface

// File: rtl/sparc_exu_div_yreg_ctl.sv
// Per-thread Y register write sequencer: pipes WRY and MULScc to their write
// stages, arbitrates same-thread writes (mul > shift > wry) and reports busy.
module sparc_exu_div_yreg_ctl #(
  parameter int unsigned NUM_THREADS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  sparc_exu_div_yreg_ctl_if.slave yif
);

  localparam int unsigned TID_W   = 2;
  localparam int unsigned THR_W   = 4;
  localparam logic [THR_W-1:0] THR_MASK = THR_W'((1 << NUM_THREADS) - 1);

  function automatic logic [THR_W-1:0] dec(input logic vld, input logic [TID_W-1:0] tid);
    dec = vld ? (THR_W'(1) << tid) : '0;
  endfunction

  logic             wry_vld_w2;
  logic [TID_W-1:0] wry_tid_w2;
  logic             ms_vld_m, ms_vld_g;
  logic [TID_W-1:0] ms_tid_m, ms_tid_g;
  logic             ms_rs1_m, ms_rs1_g;
  logic             collide_q;

  logic             wry_cap_w;
  logic             ms_cap_e;
  logic [THR_W-1:0] wry_req, shift_req, mul_req;
  logic [THR_W-1:0] wen_w, wen_g, shift_g, wen_l;
  logic [THR_W-1:0] thr_e, busy;
  logic             collide_now;
  logic             data_31;

  // Requests to unimplemented threads never enter the pipes.
  always_comb begin
    wry_cap_w = yif.wry_vld_w & ~yif.flush_w & (|(dec(1'b1, yif.wry_tid_w) & THR_MASK));
    ms_cap_e  = yif.mulscc_vld_e & (|(dec(1'b1, yif.mulscc_tid_e) & THR_MASK));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wry_vld_w2 <= 1'b0;
      wry_tid_w2 <= '0;
      ms_vld_m   <= 1'b0;
      ms_tid_m   <= '0;
      ms_rs1_m   <= 1'b0;
      ms_vld_g   <= 1'b0;
      ms_tid_g   <= '0;
      ms_rs1_g   <= 1'b0;
      collide_q  <= 1'b0;
    end else begin
      wry_vld_w2 <= wry_cap_w;
      wry_tid_w2 <= yif.wry_tid_w;
      ms_vld_m   <= ms_cap_e;
      ms_tid_m   <= yif.mulscc_tid_e;
      ms_rs1_m   <= yif.mulscc_rs1_0_e;
      ms_vld_g   <= ms_vld_m & ~yif.kill_m;
      ms_tid_g   <= ms_tid_m;
      ms_rs1_g   <= ms_rs1_m;
      collide_q  <= collide_q | collide_now;
    end
  end

  // Fixed-priority select per thread; the loser is dropped and flagged.
  always_comb begin
    wry_req     = dec(wry_vld_w2, wry_tid_w2) & THR_MASK;
    shift_req   = dec(ms_vld_g, ms_tid_g) & THR_MASK;
    mul_req     = dec(yif.mul_vld_g, yif.mul_tid_g) & THR_MASK;
    wen_g       = mul_req;
    shift_g     = shift_req & ~mul_req;
    wen_w       = wry_req & ~mul_req & ~shift_req;
    wen_l       = ~(wen_w | wen_g | shift_g);
    collide_now = |((mul_req & shift_req) | (mul_req & wry_req) | (shift_req & wry_req));
    data_31     = (|shift_g) & ms_rs1_g;
  end

  always_comb begin
    thr_e = (NUM_THREADS == 1) ? THR_W'(1) : (dec(1'b1, yif.tid_e) & THR_MASK);
    busy  = (wry_req
           | shift_req
           | dec(ms_vld_m, ms_tid_m)
           | dec(ms_cap_e, yif.mulscc_tid_e)
           | dec(wry_cap_w, yif.wry_tid_w)) & THR_MASK;
  end

  assign yif.yreg_thr_e     = thr_e;
  assign yif.yreg_wen_w     = wen_w;
  assign yif.yreg_wen_g     = wen_g;
  assign yif.yreg_shift_g   = shift_g;
  assign yif.yreg_wen_l     = wen_l;
  assign yif.yreg_data_31_g = data_31;
  assign yif.yreg_busy      = busy;
  assign yif.yreg_collide   = collide_q;

endmodule

// File: tb/tb_sparc_exu_div_yreg_ctl.sv
// Directed bench for the Y register write sequencer (4-thread and 2-thread builds).
module tb_sparc_exu_div_yreg_ctl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  sparc_exu_div_yreg_ctl_if y ();
  sparc_exu_div_yreg_ctl_if y2 ();

  sparc_exu_div_yreg_ctl #(.NUM_THREADS(4)) u_dut (.clk(clk), .reset(reset), .yif(y));
  sparc_exu_div_yreg_ctl #(.NUM_THREADS(2)) u_dut2 (.clk(clk), .reset(reset), .yif(y2));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] te, input logic wv, input logic [1:0] wt,
                       input logic fl, input logic mv, input logic [1:0] mt,
                       input logic sv, input logic [1:0] st, input logic sr,
                       input logic km);
    y.tid_e = te;  y.wry_vld_w = wv;  y.wry_tid_w = wt;  y.flush_w = fl;
    y.mul_vld_g = mv;  y.mul_tid_g = mt;  y.mulscc_vld_e = sv;
    y.mulscc_tid_e = st;  y.mulscc_rs1_0_e = sr;  y.kill_m = km;
    y2.tid_e = te;  y2.wry_vld_w = wv;  y2.wry_tid_w = wt;  y2.flush_w = fl;
    y2.mul_vld_g = mv;  y2.mul_tid_g = mt;  y2.mulscc_vld_e = sv;
    y2.mulscc_tid_e = st;  y2.mulscc_rs1_0_e = sr;  y2.kill_m = km;
  endtask

  task automatic idle();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    chk("rst_wen_w", y.yreg_wen_w, 4'b0000);
    chk("rst_wen_l", y.yreg_wen_l, 4'b1111);
    chk("rst_busy", y.yreg_busy, 4'b0000);
    chk("rst_thr_e", y.yreg_thr_e, 4'b0001);
    chk("rst_collide", {3'b0, y.yreg_collide}, 4'b0000);
    #10 reset = 1'b0;
    step();

    // WRY tid 2: write in the following cycle only
    drive(2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); #1;
    chk("wry_busy_w", y.yreg_busy, 4'b0100);
    chk("wry_wen_w_w", y.yreg_wen_w, 4'b0000);
    chk("thr_e_tid2", y.yreg_thr_e, 4'b0100);
    step();
    idle(); #1;
    chk("wry_wen_w_w2", y.yreg_wen_w, 4'b0100);
    chk("wry_wen_l_w2", y.yreg_wen_l, 4'b1011);
    chk("wry_busy_w2", y.yreg_busy, 4'b0100);
    step();
    idle(); #1;
    chk("wry_wen_w_after", y.yreg_wen_w, 4'b0000);
    chk("wry_busy_after", y.yreg_busy, 4'b0000);
    step();

    // Flushed WRY never writes
    drive(2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); #1;
    chk("flush_busy", y.yreg_busy, 4'b0000);
    step();
    idle(); #1;
    chk("flush_wen_w", y.yreg_wen_w, 4'b0000);
    chk("flush_wen_l", y.yreg_wen_l, 4'b1111);
    step();

    // MULScc chain tid 1, rs1_0 = 1,0,1
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0); #1;
    chk("ms_busy_e", y.yreg_busy, 4'b0010);
    step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0); #1;
    chk("ms_shift_c1", y.yreg_shift_g, 4'b0000);
    step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0); #1;
    chk("ms_shift_c2", y.yreg_shift_g, 4'b0010);
    chk("ms_d31_c2", {3'b0, y.yreg_data_31_g}, 4'b0001);
    step();
    idle(); #1;
    chk("ms_shift_c3", y.yreg_shift_g, 4'b0010);
    chk("ms_d31_c3", {3'b0, y.yreg_data_31_g}, 4'b0000);
    chk("ms_busy_c3", y.yreg_busy, 4'b0010);
    step();
    idle(); #1;
    chk("ms_shift_c4", y.yreg_shift_g, 4'b0010);
    chk("ms_d31_c4", {3'b0, y.yreg_data_31_g}, 4'b0001);
    step();
    idle(); #1;
    chk("ms_shift_c5", y.yreg_shift_g, 4'b0000);
    chk("ms_busy_c5", y.yreg_busy, 4'b0000);
    step();

    // Same chain with kill_m on the third cycle: middle shift removed
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0); step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0); step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1); #1;
    chk("kill_shift_c2", y.yreg_shift_g, 4'b0010);
    chk("kill_d31_c2", {3'b0, y.yreg_data_31_g}, 4'b0001);
    step();
    idle(); #1;
    chk("kill_shift_c3", y.yreg_shift_g, 4'b0000);
    chk("kill_d31_c3", {3'b0, y.yreg_data_31_g}, 4'b0000);
    chk("kill_wen_l_c3", y.yreg_wen_l, 4'b1111);
    step();
    idle(); #1;
    chk("kill_shift_c4", y.yreg_shift_g, 4'b0010);
    chk("kill_d31_c4", {3'b0, y.yreg_data_31_g}, 4'b0001);
    step();
    idle(); #1;
    chk("kill_shift_c5", y.yreg_shift_g, 4'b0000);
    step();

    // Multiply tid 1 alongside W2 WRY tid 0: both write
    drive(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0); #1;
    chk("diff_wen_w", y.yreg_wen_w, 4'b0001);
    chk("diff_wen_g", y.yreg_wen_g, 4'b0010);
    chk("diff_wen_l", y.yreg_wen_l, 4'b1100);
    step();
    idle(); #1;
    chk("diff_collide", {3'b0, y.yreg_collide}, 4'b0000);
    step();

    // Multiply tid 0 against W2 WRY tid 0: multiply wins, sticky collide
    drive(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); step();
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0); #1;
    chk("col_wen_g", y.yreg_wen_g, 4'b0001);
    chk("col_wen_w", y.yreg_wen_w, 4'b0000);
    chk("col_wen_l", y.yreg_wen_l, 4'b1110);
    step();
    idle(); #1;
    chk("col_flag", {3'b0, y.yreg_collide}, 4'b0001);
    chk("col_wen_g_after", y.yreg_wen_g, 4'b0000);
    step();
    step();
    chk("col_sticky", {3'b0, y.yreg_collide}, 4'b0001);

    // Thread 3 traffic: writes on the 4-thread build, ignored on the 2-thread build
    drive(2'd3, 1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0); #1;
    chk("nt4_thr_e3", y.yreg_thr_e, 4'b1000);
    chk("nt4_wen_g3", y.yreg_wen_g, 4'b1000);
    chk("nt2_thr_e3", y2.yreg_thr_e, 4'b0000);
    chk("nt2_wen_g3", y2.yreg_wen_g, 4'b0000);
    chk("nt2_busy3", y2.yreg_busy, 4'b0000);
    chk("nt2_wen_l3", y2.yreg_wen_l, 4'b1111);
    step();
    idle(); #1;
    chk("nt4_wen_w3", y.yreg_wen_w, 4'b1000);
    chk("nt2_wen_w3", y2.yreg_wen_w, 4'b0000);
    chk("nt2_wen_l3_w2", y2.yreg_wen_l, 4'b1111);
    step();
    idle(); #1;
    chk("nt4_shift3", y.yreg_shift_g, 4'b1000);
    chk("nt2_shift3", y2.yreg_shift_g, 4'b0000);
    chk("nt2_d31", {3'b0, y2.yreg_data_31_g}, 4'b0000);
    step();

    // Random traffic: one-hot selects and busy covering visible updates
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] need;
      logic [3:0] onehot_ok;
      logic       wv, fl, sv;
      logic [1:0] wt, st;
      wv = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 7) == 0);
      sv = 1'($urandom_range(0, 1));
      wt = 2'($urandom_range(0, 3));
      st = 2'($urandom_range(0, 3));
      drive(2'($urandom_range(0, 3)), wv, wt, fl, ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), sv, st, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      #1;
      for (int t = 0; t < 4; t++)
        onehot_ok[t] = ($countones({y.yreg_wen_w[t], y.yreg_wen_g[t],
                                    y.yreg_shift_g[t], y.yreg_wen_l[t]}) == 1);
      need = y.yreg_wen_w | y.yreg_shift_g
           | (sv ? (4'b0001 << st) : 4'b0000)
           | ((wv & ~fl) ? (4'b0001 << wt) : 4'b0000);
      chk("rnd_onehot", onehot_ok, 4'b1111);
      chk("rnd_busy", y.yreg_busy & need, need);
      chk("rnd_nt2_wen_l_hi", {2'b00, y2.yreg_wen_l[3:2]}, 4'b0011);
      step();
    end

    // Reset mid-cycle with WRY and MULScc in flight
    drive(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0); step();
    drive(2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0); step();
    idle(); #1;
    chk("pre_rst_wen_w", y.yreg_wen_w, 4'b0010);
    chk("pre_rst_shift", y.yreg_shift_g, 4'b1000);
    chk("pre_rst_busy", y.yreg_busy, 4'b1110);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wen_w", y.yreg_wen_w, 4'b0000);
    chk("mid_rst_shift", y.yreg_shift_g, 4'b0000);
    chk("mid_rst_wen_l", y.yreg_wen_l, 4'b1111);
    chk("mid_rst_d31", {3'b0, y.yreg_data_31_g}, 4'b0000);
    chk("mid_rst_busy", y.yreg_busy, 4'b0000);
    chk("mid_rst_collide", {3'b0, y.yreg_collide}, 4'b0000);
    @(posedge clk);
    #3 reset = 1'b0;
    step();
    chk("post_rst_wen_w", y.yreg_wen_w, 4'b0000);
    chk("post_rst_shift", y.yreg_shift_g, 4'b0000);
    chk("post_rst_busy", y.yreg_busy, 4'b0000);
    step();
    chk("post_rst_shift2", y.yreg_shift_g, 4'b0000);
    chk("post_rst_wen_l", y.yreg_wen_l, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
